// File: rtl/dmem_arbiter_if.sv
// Request/response ports of the two data-memory requesters plus the memory port.
// slave is the arbiter's view; master is the view of the surrounding logic.
interface dmem_arbiter_if #(
  parameter int unsigned MEM_WORDS = 64
);
  localparam int unsigned MAW = $clog2(MEM_WORDS);

  logic            core_req;
  logic            core_we;
  logic [31:0]     core_adr;
  logic [31:0]     core_wdata;
  logic            core_gnt;
  logic            core_rvalid;
  logic [31:0]     core_rdata;

  logic            dma_req;
  logic            dma_we;
  logic [31:0]     dma_adr;
  logic [31:0]     dma_wdata;
  logic            dma_gnt;
  logic            dma_rvalid;
  logic [31:0]     dma_rdata;

  logic            mem_en;
  logic            mem_we;
  logic [MAW-1:0]  mem_adr;
  logic [31:0]     mem_wdata;
  logic [31:0]     mem_rdata;

  logic            addr_err;

  modport slave (
    input  core_req, core_we, core_adr, core_wdata,
    output core_gnt, core_rvalid, core_rdata,
    input  dma_req, dma_we, dma_adr, dma_wdata,
    output dma_gnt, dma_rvalid, dma_rdata,
    output mem_en, mem_we, mem_adr, mem_wdata,
    input  mem_rdata,
    output addr_err
  );

  modport master (
    output core_req, core_we, core_adr, core_wdata,
    input  core_gnt, core_rvalid, core_rdata,
    output dma_req, dma_we, dma_adr, dma_wdata,
    input  dma_gnt, dma_rvalid, dma_rdata,
    input  mem_en, mem_we, mem_adr, mem_wdata,
    output mem_rdata,
    input  addr_err
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Core/DMA arbiter for the single-ported synchronous-read data memory.
// Optional address checking is enabled by defining DMEM_ADDR_CHECK_EN.
module dmem_arbiter #(
  parameter int unsigned MEM_WORDS    = 64,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic           clk,
  input logic           reset,
  dmem_arbiter_if.slave bus
);
  localparam int unsigned MAW = $clog2(MEM_WORDS);
  localparam int unsigned CW  = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CORE_RD = 2'd1,
    DMA_RD  = 2'd2
  } state_t;

  state_t          state;
  state_t          stateNext;
  logic [CW-1:0]   starveCnt;
  logic [CW-1:0]   starveCntNext;
  logic [MAW-1:0]  adrQ;
  logic [MAW-1:0]  adrNext;
  logic [31:0]     wdataQ;
  logic [31:0]     wdataNext;
  logic [31:0]     coreRdataQ;
  logic [31:0]     dmaRdataQ;
  logic            errRdQ;
  logic            errRdNext;

  logic            dmaForce;
  logic            coreGnt;
  logic            dmaGnt;
  logic            anyGnt;
  logic            winWe;
  logic [31:0]     winAdr;
  logic [31:0]     winWdata;
  logic            accErr;
  logic            memEn;
  logic [31:0]     rspData;

`ifdef DMEM_ADDR_CHECK_EN
  // Misaligned or out-of-range accesses are granted but never reach the memory.
  assign accErr = anyGnt && ((winAdr[1:0] != 2'b00) || (winAdr >= 32'(4 * MEM_WORDS)));
`else
  logic unusedAdrBits;
  assign accErr        = 1'b0;
  assign unusedAdrBits = ^{winAdr[1:0], winAdr[31:MAW+2]};
`endif

  // Read data returned in the response cycle; a rejected read answers with a marker.
  assign rspData = errRdQ ? 32'hDEAD_BEEF : bus.mem_rdata;

  // FSM state register: owner of the read in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Arbitration, memory drive, next state and response outputs.
  always_comb begin
    stateNext     = IDLE;
    coreGnt       = 1'b0;
    dmaGnt        = 1'b0;
    dmaForce      = (starveCnt == CW'(STARVE_LIMIT));
    starveCntNext = starveCnt;

    if (reset) begin
      if (bus.dma_req && (dmaForce || !bus.core_req)) begin
        dmaGnt = 1'b1;
      end else if (bus.core_req) begin
        coreGnt = 1'b1;
      end
    end
    anyGnt = coreGnt || dmaGnt;

    winWe    = dmaGnt ? bus.dma_we    : bus.core_we;
    winAdr   = dmaGnt ? bus.dma_adr   : bus.core_adr;
    winWdata = dmaGnt ? bus.dma_wdata : bus.core_wdata;
    memEn    = anyGnt && !accErr;

    // Address and data hold their last driven values while the memory is idle.
    adrNext   = memEn ? winAdr[MAW+1:2] : adrQ;
    wdataNext = memEn ? winWdata : wdataQ;

    if (coreGnt && !bus.core_we) begin
      stateNext = CORE_RD;
    end else if (dmaGnt && !bus.dma_we) begin
      stateNext = DMA_RD;
    end
    errRdNext = accErr && !winWe;

    if (!bus.dma_req || dmaGnt) begin
      starveCntNext = '0;
    end else if (!dmaForce) begin
      starveCntNext = starveCnt + CW'(1);
    end

    bus.core_gnt    = coreGnt;
    bus.dma_gnt     = dmaGnt;
    bus.mem_en      = memEn;
    bus.mem_we      = memEn && winWe;
    bus.mem_adr     = reset ? adrNext : '0;
    bus.mem_wdata   = reset ? wdataNext : '0;
    bus.addr_err    = accErr;
    bus.core_rvalid = reset && (state == CORE_RD);
    bus.dma_rvalid  = reset && (state == DMA_RD);
    bus.core_rdata  = '0;
    bus.dma_rdata   = '0;
    if (reset) begin
      bus.core_rdata = (state == CORE_RD) ? rspData : coreRdataQ;
      bus.dma_rdata  = (state == DMA_RD)  ? rspData : dmaRdataQ;
    end
  end

  // Datapath registers: starvation counter, held memory drive, held read data.
  always_ff @(posedge clk) begin
    if (!reset) begin
      starveCnt  <= '0;
      adrQ       <= '0;
      wdataQ     <= '0;
      coreRdataQ <= '0;
      dmaRdataQ  <= '0;
      errRdQ     <= 1'b0;
    end else begin
      starveCnt <= starveCntNext;
      adrQ      <= adrNext;
      wdataQ    <= wdataNext;
      errRdQ    <= errRdNext;
      if (state == CORE_RD) begin
        coreRdataQ <= rspData;
      end
      if (state == DMA_RD) begin
        dmaRdataQ <= rspData;
      end
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed plan steps followed by random traffic,
// all compared against a transaction-level reference model of memory and arbitration.
module tb_dmem_arbiter;
  localparam int unsigned MEM_WORDS    = 64;
  localparam int unsigned STARVE_LIMIT = 4;
  localparam logic [31:0] ADR_LIMIT    = 32'(4 * MEM_WORDS);

  logic clk;
  logic rst;

  dmem_arbiter_if #(.MEM_WORDS(MEM_WORDS)) bus ();

  dmem_arbiter #(
    .MEM_WORDS   (MEM_WORDS),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_dut (
    .clk  (clk),
    .reset(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read, write-first memory stub.
  logic [31:0] memArr [MEM_WORDS];
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) begin
        memArr[bus.mem_adr] <= bus.mem_wdata;
        bus.mem_rdata       <= bus.mem_wdata;
      end else begin
        bus.mem_rdata <= memArr[bus.mem_adr];
      end
    end
  end

  int          nChecks;
  int          nFails;
  logic [31:0] refMem [MEM_WORDS];
  int          refStarve;
  int          pend;
  logic [31:0] pendData;
  logic [31:0] expCoreRd;
  logic [31:0] expDmaRd;
  logic [31:0] expAdr;
  logic [31:0] expWd;
  logic        gnC;
  logic        gnD;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rndAdr();
    if ($urandom_range(0, 7) == 0) return $urandom;
    return 32'($urandom_range(0, MEM_WORDS - 1)) * 32'd4;
  endfunction

  // One clock cycle: drive at negedge, check outputs, then advance the reference model.
  task automatic step(input logic rs, input logic cr, input logic cw,
                      input logic [31:0] ca, input logic [31:0] cd,
                      input logic dr, input logic dw,
                      input logic [31:0] da, input logic [31:0] dd,
                      output logic cg, output logic dg);
    logic        err;
    logic        we;
    logic        acc;
    logic [31:0] a;
    logic [31:0] d;
    int          idx;
    @(negedge clk);
    rst            = rs;
    bus.core_req   = cr;
    bus.core_we    = cw;
    bus.core_adr   = ca;
    bus.core_wdata = cd;
    bus.dma_req    = dr;
    bus.dma_we     = dw;
    bus.dma_adr    = da;
    bus.dma_wdata  = dd;
    #1;
    dg  = rs && dr && (refStarve >= int'(STARVE_LIMIT) || !cr);
    cg  = rs && cr && !dg;
    we  = dg ? dw : cw;
    a   = dg ? da : ca;
    d   = dg ? dd : cd;
    err = 1'b0;
`ifdef DMEM_ADDR_CHECK_EN
    err = (cg || dg) && ((a % 4) != 0 || a >= ADR_LIMIT);
`endif
    acc = (cg || dg) && !err;
    idx = int'((a / 4) % MEM_WORDS);

    chk("core_gnt", 32'(bus.core_gnt), 32'(cg));
    chk("dma_gnt", 32'(bus.dma_gnt), 32'(dg));
    chk("mem_en", 32'(bus.mem_en), 32'(acc));
    chk("mem_we", 32'(bus.mem_we), 32'(acc && we));
    chk("mem_adr", 32'(bus.mem_adr), !rs ? 32'd0 : (acc ? 32'(idx) : expAdr));
    chk("mem_wdata", bus.mem_wdata, !rs ? 32'd0 : (acc ? d : expWd));
    chk("addr_err", 32'(bus.addr_err), 32'(err));
    chk("core_rvalid", 32'(bus.core_rvalid), 32'(rs && pend == 1));
    chk("dma_rvalid", 32'(bus.dma_rvalid), 32'(rs && pend == 2));
    chk("core_rdata", bus.core_rdata, !rs ? 32'd0 : (pend == 1 ? pendData : expCoreRd));
    chk("dma_rdata", bus.dma_rdata, !rs ? 32'd0 : (pend == 2 ? pendData : expDmaRd));

    if (!rs) begin
      refStarve = 0;
      pend      = 0;
      expCoreRd = '0;
      expDmaRd  = '0;
      expAdr    = '0;
      expWd     = '0;
    end else begin
      if (pend == 1) expCoreRd = pendData;
      if (pend == 2) expDmaRd = pendData;
      pend = 0;
      if (acc) begin
        expAdr = 32'(idx);
        expWd  = d;
        if (we) refMem[idx] = d;
      end
      if ((cg || dg) && !we) begin
        pend     = cg ? 1 : 2;
        pendData = err ? 32'hDEAD_BEEF : refMem[idx];
      end
      if (!dr || dg) refStarve = 0;
      else if (refStarve < int'(STARVE_LIMIT)) refStarve++;
    end
  endtask

  task automatic coreOp(input logic w, input logic [31:0] a, input logic [31:0] d);
    step(1'b1, 1'b1, w, a, d, 1'b0, 1'b0, '0, '0, gnC, gnD);
  endtask

  task automatic dmaOp(input logic w, input logic [31:0] a, input logic [31:0] d);
    step(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, w, a, d, gnC, gnD);
  endtask

  task automatic idle(input logic rs);
    step(rs, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, gnC, gnD);
  endtask

  logic        cAct, cWe, dAct, dWe, rs;
  logic [31:0] cAdr, cDat, dAdr, dDat;
  logic [31:0] preload [4];

  initial begin
    nChecks   = 0;
    nFails    = 0;
    refStarve = 0;
    pend      = 0;
    pendData  = '0;
    expCoreRd = '0;
    expDmaRd  = '0;
    expAdr    = '0;
    expWd     = '0;
    for (int i = 0; i < int'(MEM_WORDS); i++) refMem[i] = '0;
    rst = 1'b0;

    // Reset state, then zero-fill the memory through the DMA port.
    repeat (3) idle(1'b0);
    idle(1'b1);
    for (int i = 0; i < int'(MEM_WORDS); i++) dmaOp(1'b1, 32'(i) * 32'd4, 32'd0);
    idle(1'b1);

    // Core write then read of the top word.
    coreOp(1'b1, 32'd252, 32'd9);
    chk("tp1_gnt", 32'(bus.core_gnt), 32'd1);
    chk("tp1_adr", 32'(bus.mem_adr), 32'd63);
    chk("tp1_wdata", bus.mem_wdata, 32'd9);
    coreOp(1'b0, 32'd252, 32'd0);
    idle(1'b1);
    chk("tp1_rvalid", 32'(bus.core_rvalid), 32'd1);
    chk("tp1_rdata", bus.core_rdata, 32'd9);
    idle(1'b1);

    // Both requesters held: DMA wins every fifth cycle.
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'(i) * 32'd4, '0, 1'b1, 1'b0, 32'd40, '0, gnC, gnD);
      chk("starve_dma", 32'(bus.dma_gnt), 32'((i % 5) == 4));
      chk("starve_core", 32'(bus.core_gnt), 32'((i % 5) != 4));
    end
    idle(1'b1);

    // Alternating back-to-back reads with no bubble.
    coreOp(1'b1, 32'd96, 32'd7);
    dmaOp(1'b1, 32'd100, 32'd5);
    coreOp(1'b0, 32'd96, '0);
    dmaOp(1'b0, 32'd100, '0);
    chk("alt_core_rv", 32'(bus.core_rvalid), 32'd1);
    chk("alt_core_rd", bus.core_rdata, 32'd7);
    coreOp(1'b0, 32'd96, '0);
    chk("alt_dma_rv", 32'(bus.dma_rvalid), 32'd1);
    chk("alt_dma_rd", bus.dma_rdata, 32'd5);
    dmaOp(1'b0, 32'd100, '0);
    idle(1'b1);

    // DMA preload, core read of word 2, counter restarts from zero.
    preload[0] = 32'd22;
    preload[1] = 32'd3;
    preload[2] = 32'd5;
    preload[3] = 32'd2;
    for (int i = 0; i < 4; i++) dmaOp(1'b1, 32'(i) * 32'd4, preload[i]);
    coreOp(1'b0, 32'd8, '0);
    idle(1'b1);
    chk("pre_rdata", bus.core_rdata, 32'd5);
    step(1'b1, 1'b1, 1'b0, 32'd0, '0, 1'b1, 1'b0, 32'd4, '0, gnC, gnD);
    chk("pre_cnt_zero", 32'(bus.core_gnt), 32'd1);
    idle(1'b1);

    // Out-of-range read of byte address 256.
    coreOp(1'b0, 32'd256, '0);
    chk("chk_gnt", 32'(bus.core_gnt), 32'd1);
`ifdef DMEM_ADDR_CHECK_EN
    chk("chk_err", 32'(bus.addr_err), 32'd1);
    chk("chk_en", 32'(bus.mem_en), 32'd0);
    idle(1'b1);
    chk("chk_rdata", bus.core_rdata, 32'hDEAD_BEEF);
`else
    chk("chk_err", 32'(bus.addr_err), 32'd0);
    chk("chk_en", 32'(bus.mem_en), 32'd1);
    idle(1'b1);
    chk("chk_rdata", bus.core_rdata, 32'd22);
`endif
    chk("chk_rvalid", 32'(bus.core_rvalid), 32'd1);

    // Read granted, then reset: no response and all outputs low.
    coreOp(1'b0, 32'd8, '0);
    idle(1'b0);
    chk("rst_rvalid", 32'(bus.core_rvalid), 32'd0);
    chk("rst_rdata", bus.core_rdata, 32'd0);
    idle(1'b0);
    idle(1'b1);
    chk("rst_after", 32'(bus.core_rvalid), 32'd0);

    // Random traffic with requests held until granted.
    cAct = 1'b0;
    dAct = 1'b0;
    cWe  = 1'b0;
    dWe  = 1'b0;
    cAdr = '0;
    dAdr = '0;
    cDat = '0;
    dDat = '0;
    for (int i = 0; i < 500; i++) begin
      if (!cAct && $urandom_range(0, 2) != 0) begin
        cAct = 1'b1;
        cWe  = 1'($urandom_range(0, 1));
        cAdr = rndAdr();
        cDat = $urandom;
      end
      if (!dAct && $urandom_range(0, 1) != 0) begin
        dAct = 1'b1;
        dWe  = 1'($urandom_range(0, 1));
        dAdr = rndAdr();
        dDat = $urandom;
      end
      rs = ($urandom_range(0, 99) != 0);
      step(rs, cAct, cWe, cAdr, cDat, dAct, dWe, dAdr, dDat, gnC, gnD);
      if (gnC || !rs) cAct = 1'b0;
      if (gnD || !rs) dAct = 1'b0;
    end
    idle(1'b1);
    idle(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-ported data memory between two requesters: the processor core (load/store port) and a DMA/test-loader port that preloads and inspects memory around reset.
- Fixed priority to the core, with a starvation counter that guarantees DMA forward progress.
- One transfer per cycle. Synchronous-read memory: read data returns one cycle after grant.
- Sits between the core's memory port and the data memory inside top.

Parameters:
- MEM_WORDS, 64, depth of data memory in 32-bit words (power of two).
- STARVE_LIMIT, 4, number of consecutive denied DMA request cycles after which DMA is forced to win.
- MAW, $clog2(MEM_WORDS), memory word-address width (derived, not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- core_req  in  1  core access request, held until granted.
- core_we  in  1  core write (1) / read (0).
- core_adr  in  32  core byte address.
- core_wdata  in  32  core write data.
- core_gnt  out  1  core access accepted this cycle.
- core_rvalid  out  1  core read data valid.
- core_rdata  out  32  core read data.
- dma_req  in  1  DMA access request, held until granted.
- dma_we  in  1  DMA write / read.
- dma_adr  in  32  DMA byte address.
- dma_wdata  in  32  DMA write data.
- dma_gnt  out  1  DMA access accepted this cycle.
- dma_rvalid  out  1  DMA read data valid.
- dma_rdata  out  32  DMA read data.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_adr  out  MAW  memory word address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data, valid one cycle after a read with mem_en=1.
- addr_err  out  1  address error pulse (present only with the optional feature).

Behaviour:
- Reset (reset==0 at a rising edge):
  - All gnt, rvalid and mem_en/mem_we are 0.
  - Both rdata outputs are 0.
  - Starvation counter is 0.
  - FSM goes to IDLE.
  - The response pipeline is flushed, so a read granted in the cycle reset asserts never produces an rvalid.
- Grant is combinational in the request cycle:
  - At most one of core_gnt/dma_gnt is high.
  - gnt is never high without the matching req.
- Arbitration:
  - dma_force = (starve_cnt == STARVE_LIMIT).
  - If dma_req && (dma_force || !core_req): grant DMA. Otherwise, if core_req: grant core.
- Starvation counter:
  - Increments each cycle dma_req=1 and DMA is not granted, saturating at STARVE_LIMIT.
  - Clears on a DMA grant or when dma_req=0.
  - While the DMA is forced, core_req stays pending (core stalls one cycle).
- Memory drive:
  - mem_en = any gnt.
  - mem_we, mem_adr and mem_wdata come from the winner. mem_adr = adr[MAW+1:2]; bits [1:0] and the bits above MAW+1 are ignored.
  - Idle cycles: mem_we=0, and mem_adr/mem_wdata hold their last values.
- FSM states IDLE, CORE_RD, DMA_RD (tracks the owner of the in-flight read):
  - Any state goes to CORE_RD on a core read grant, to DMA_RD on a DMA read grant, and to IDLE otherwise (write or no grant).
- Read response:
  - In state CORE_RD: core_rvalid=1 for exactly one cycle, and core_rdata = mem_rdata. Same rule for DMA_RD with the dma_* outputs.
  - rdata holds its last value when rvalid=0.
  - Back-to-back reads: a new grant is allowed in the same cycle as the previous rvalid (full throughput, latency 1).
- Writes produce no rvalid and complete in the grant cycle.
- Read-after-write to the same address in consecutive cycles returns the new data (the memory is write-first; the arbiter adds no bypass).
- Simultaneous req from both with core_we=1 and dma_we=1: only the winner writes. The loser's request stays pending.

Optional Feature:
- DMEM_ADDR_CHECK_EN defined:
  - A granted access whose adr[1:0]!=0, or whose adr >= 4*MEM_WORDS, is still granted (no hang), but mem_en is forced to 0.
  - addr_err pulses high in the grant cycle.
  - A read gets rvalid the next cycle with rdata=32'hDEADBEEF.
- Not defined:
  - addr_err is tied to 0.
  - Addresses wrap modulo MEM_WORDS and the low two bits are ignored.

Test Plan:
- Reset then core write adr=252 data=9 with no DMA -> core_gnt=1 the same cycle, mem_we=1, mem_adr=63, mem_wdata=9. Then a core read of 252 -> core_rvalid=1 one cycle later, core_rdata=9.
- dma_req and core_req both held high continuously, STARVE_LIMIT=4 -> core granted 4 cycles, DMA granted on the 5th, core stalled that cycle. Pattern repeats with a period of 5.
- Alternating core read of 96 / DMA read of 100, back to back (mem holds 7 at 96 and 5 at 100) -> core_rvalid with 7, then dma_rvalid with 5. Never both rvalids high. No bubble cycles.
- DMA preloads words 0..3 with 22,3,5,2, then releases; core reads word 2 -> rdata=5. DMA counter is 0 after dma_req drops.
- Core read granted, reset deasserted-low (asserted) the next edge -> no core_rvalid, all outputs 0 while reset=0.
- With DMEM_ADDR_CHECK_EN: core read adr=256 (MEM_WORDS=64) -> core_gnt=1, addr_err=1, mem_en=0, next cycle core_rvalid=1 with 32'hDEADBEEF. Without the macro: the same access reads word 0.
